// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file plus interrupt/trap controller for the
// memory stage of the RV32I pipeline. Holds mstatus (MIE/MPIE), mie
// (MTIE/MEIE), mip (MTIP/MEIP), mtvec, mepc and mcause, takes enabled
// timer/external interrupts on valid instructions, handles MRET, and
// drives the PC redirect consumed by fetch and flush logic.
module csr_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid,
  input  logic [XLEN-1:0] pc,
  input  logic [11:0]     addr,
  input  logic [XLEN-1:0] wdata,
  input  logic            csr_reg_wr,
  input  logic            csr_reg_rd,
  input  logic            is_mret,
  input  logic            timer_intr,
  input  logic            ext_intr,
  output logic [XLEN-1:0] rdata,
  output logic            epc_taken,
  output logic [XLEN-1:0] epc
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  localparam int unsigned CAUSE_W = 5;
  localparam logic [CAUSE_W-1:0] CAUSE_EXT   = 5'd11;
  localparam logic [CAUSE_W-1:0] CAUSE_TIMER = 5'd7;

  // Architectural state
  logic            mst_mie_q,  mst_mie_d;
  logic            mst_mpie_q, mst_mpie_d;
  logic            mie_mtie_q, mie_mtie_d;
  logic            mie_meie_q, mie_meie_d;
  logic            mip_mtip_q, mip_mtip_d;
  logic            mip_meip_q, mip_meip_d;
  logic [XLEN-1:0] mtvec_q,    mtvec_d;
  logic [XLEN-1:0] mepc_q,     mepc_d;
  logic [XLEN-1:0] mcause_q,   mcause_d;

  // Trap control
  logic               pend_e;
  logic               pend_t;
  logic               irq_take;
  logic               mret_take;
  logic               csr_we;
  logic [CAUSE_W-1:0] cause;
  logic [XLEN-1:0]    tvec_base;
  logic               tvec_vectored;
  logic [XLEN-1:0]    csr_val;

  // Interrupt detection, MRET qualification and write gating
  always_comb begin
    pend_e        = mie_meie_q & mip_meip_q;
    pend_t        = mie_mtie_q & mip_mtip_q;
    irq_take      = valid & mst_mie_q & (pend_e | pend_t) & ~is_mret;
    mret_take     = is_mret & valid;
    csr_we        = csr_reg_wr & valid & ~irq_take & ~is_mret;
    cause         = pend_e ? CAUSE_EXT : CAUSE_TIMER;
    tvec_base     = {mtvec_q[XLEN-1:2], 2'b00};
    tvec_vectored = (mtvec_q[1:0] == 2'b01);
  end

  // Redirect target: MRET returns to mepc, interrupts go to the trap vector
  always_comb begin
    epc_taken = irq_take | mret_take;
    epc       = '0;
    if (mret_take) begin
      epc = mepc_q;
    end else if (irq_take) begin
      epc = tvec_vectored ? (tvec_base + XLEN'({cause, 2'b00})) : tvec_base;
    end
  end

  // CSR read mux; unmapped addresses read zero
  always_comb begin
    csr_val = '0;
    case (addr)
      ADDR_MSTATUS: csr_val = XLEN'({mst_mpie_q, 3'b000, mst_mie_q, 3'b000});
      ADDR_MIE:     csr_val = XLEN'({mie_meie_q, 3'b000, mie_mtie_q, 7'b0000000});
      ADDR_MTVEC:   csr_val = mtvec_q;
      ADDR_MEPC:    csr_val = mepc_q;
      ADDR_MCAUSE:  csr_val = mcause_q;
      ADDR_MIP:     csr_val = XLEN'({mip_meip_q, 3'b000, mip_mtip_q, 7'b0000000});
      default:      csr_val = '0;
    endcase
    rdata = csr_reg_rd ? csr_val : '0;
  end

  // Next-state: software writes, interrupt entry and MRET are mutually exclusive
  always_comb begin
    mst_mie_d  = mst_mie_q;
    mst_mpie_d = mst_mpie_q;
    mie_mtie_d = mie_mtie_q;
    mie_meie_d = mie_meie_q;
    mip_mtip_d = timer_intr;
    mip_meip_d = ext_intr;
    mtvec_d    = mtvec_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;

    if (irq_take) begin
      mepc_d     = pc;
      mcause_d   = {1'b1, (XLEN-1)'(cause)};
      mst_mpie_d = mst_mie_q;
      mst_mie_d  = 1'b0;
    end else if (mret_take) begin
      mst_mie_d  = mst_mpie_q;
      mst_mpie_d = 1'b1;
    end else if (csr_we) begin
      case (addr)
        ADDR_MSTATUS: begin
          mst_mie_d  = wdata[3];
          mst_mpie_d = wdata[7];
        end
        ADDR_MIE: begin
          mie_mtie_d = wdata[7];
          mie_meie_d = wdata[11];
        end
        ADDR_MTVEC:  mtvec_d  = wdata;
        ADDR_MEPC:   mepc_d   = {wdata[XLEN-1:2], 2'b00};
        ADDR_MCAUSE: mcause_d = wdata;
        default: ;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mst_mie_q  <= 1'b0;
      mst_mpie_q <= 1'b0;
      mie_mtie_q <= 1'b0;
      mie_meie_q <= 1'b0;
      mip_mtip_q <= 1'b0;
      mip_meip_q <= 1'b0;
      mtvec_q    <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else begin
      mst_mie_q  <= mst_mie_d;
      mst_mpie_q <= mst_mpie_d;
      mie_mtie_q <= mie_mtie_d;
      mie_meie_q <= mie_meie_d;
      mip_mtip_q <= mip_mtip_d;
      mip_meip_q <= mip_meip_d;
      mtvec_q    <= mtvec_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
    end
  end

endmodule

// File: doc/csr_unit.md
# csr_unit

Machine-mode CSR file and interrupt/trap controller for the pipelined RV32I core. It sits in the memory stage, directly downstream of the decoder, and consumes the decoder's `CSR_reg_wr`, `CSR_reg_rd` and `is_mret` controls after they have been piped to this stage. It holds `mstatus`, `mie`, `mip`, `mtvec`, `mepc` and `mcause`, and returns CSR read data for writeback select `wb_sel = 2'b11`. It detects enabled timer and external interrupts, and drives the PC redirect (`epc_taken`/`epc`) that the fetch stage and pipeline flush logic consume.

## Interface
- `XLEN`, 32, data/PC width (only 32 supported)
- `clk`  in  1  core clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `valid`  in  1  a real (non-bubble) instruction occupies the memory stage
- `pc`  in  32  PC of the memory-stage instruction
- `addr`  in  12  CSR address (`inst[31:20]`)
- `wdata`  in  32  CSR write data (rs1 value)
- `csr_reg_wr`  in  1  CSR write request (from decoder `CSR_reg_wr`)
- `csr_reg_rd`  in  1  CSR read request (from decoder `CSR_reg_rd`)
- `is_mret`  in  1  MRET in this stage
- `timer_intr`  in  1  machine timer interrupt line, level
- `ext_intr`  in  1  machine external interrupt line, level
- `rdata`  out  32  CSR read data
- `epc_taken`  out  1  redirect the PC to `epc` and flush younger stages
- `epc`  out  32  redirect target

## Operation
- **Address map.** `mstatus` 0x300, `mie` 0x304, `mtvec` 0x305, `mepc` 0x341, `mcause` 0x342, `mip` 0x344.
  - Any other address reads 0, and writes to it are ignored.
- **`mstatus`.** Only MIE[3] and MPIE[7] are stored; all other bits read 0.
- **`mie`.** Only MTIE[7] and MEIE[11] are stored.
- **`mip`.** Read-only; writes are ignored. MTIP[7] and MEIP[11] are registered copies of `timer_intr`/`ext_intr`, updated every cycle.
- **`mtvec`.** Full 32 bits stored. Mode = [1:0] (0 direct, 1 vectored; 2/3 behave as direct). Base = {[31:2], 2'b00}.
- **`mepc`.** Full 32 bits stored; bits [1:0] are forced to 0 on write.
- **`mcause`.** Full 32 bits stored.
- **Read.**
  - `rdata` = selected CSR when `csr_reg_rd`=1, else 0. Combinational.
  - A read of `mip` returns the registered value.
- **Write.** At the clock edge when `csr_reg_wr & valid & ~irq_take & ~is_mret`.
- **Interrupt detection.**
  - `pend_e` = MEIE & MEIP; `pend_t` = MTIE & MTIP.
  - `irq_take` = `valid` & MIE & (`pend_e` | `pend_t`) & ~`is_mret`.
  - External has priority over timer: cause 11 if `pend_e`, else 7.
- **Interrupt entry (edge after `irq_take`).**
  - `mepc` <= `pc`. The interrupted instruction is discarded and re-executes after MRET, so its CSR write is suppressed.
  - `mcause` <= 0x8000_000B (external) or 0x8000_0007 (timer).
  - MPIE <= MIE; MIE <= 0.
- **MRET (edge after `is_mret & valid`).** MIE <= MPIE; MPIE <= 1.
  - MRET has priority over a simultaneous interrupt. The interrupt is re-evaluated next cycle with the restored MIE.
- **Redirect.**
  - `epc_taken` = `irq_take` | (`is_mret` & `valid`).
  - `epc` on MRET = `mepc`.
  - `epc` on interrupt, direct mode = base.
  - `epc` on interrupt, vectored mode = base + 4·cause (+44 external, +28 timer), 32-bit wrap.
  - `epc` when not taken = 0.

## Timing
- **Reset.** All CSRs and `mip` reset to 0. With `is_mret`/`csr_reg_rd` low, `rdata`=0, `epc_taken`=0, `epc`=0. Reset deasserted mid-trap leaves no partial state.
- **Interrupt path latency.**
  - Interrupt line to `mip`: 1 cycle.
  - `mip` to `epc_taken`: combinational, same cycle as a `valid` instruction with MIE=1.
  - Total: an interrupt asserted in cycle N can redirect in cycle N+1 at the earliest.
- **State updates** (`mepc`/`mcause`/`mstatus`) are visible on the edge that ends the `epc_taken` cycle.
- **Reads** are combinational. A write in cycle N is visible to a read in cycle N+1, with no internal bypass.
- **No interrupts with `valid`=0.** `epc_taken` stays low while `valid`=0 (bubbles/stalls), even if an interrupt is pending.
- **MIE=0 during entry.** The cycle after entry has MIE=0, so no back-to-back re-entry is possible.

## Test plan
- **Reset.** Assert `rst` asynchronously mid-cycle → all reads 0, `epc_taken`=0 immediately, no clock needed.
- **Write/read.** Write 0x0000_1001 to `mtvec`, 0xFFFF_FFFF to `mstatus` and to 0x7C0 → reads return 0x0000_1001, 0x0000_0088 and 0.
- **Timer interrupt, vectored.** `mtvec`=0x1001, `mie`=0x80, `mstatus`=0x8, `timer_intr`=1, `valid`=1, `pc`=0x200 → `epc_taken`=1 one cycle after the line rises, `epc`=0x101C. Next cycle: `mepc`=0x200, `mcause`=0x8000_0007, `mstatus`=0x80.
- **Simultaneous interrupts.** Both interrupt lines high with both enables set → cause 0x8000_000B, `epc`=base+44. A CSR write in the same cycle is dropped.
- **MRET.** After entry, MRET with `valid` → `epc`=0x200, `mstatus` returns to 0x88. A pending interrupt during the MRET cycle is taken on the next valid cycle.
- **Bubble.** Pending interrupt with `valid`=0 for 3 cycles → `epc_taken` stays 0. It fires on the first `valid`=1 cycle with that cycle's `pc` saved.
